ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_sync_edge.sv | 29 ++
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared types: FSM states, error codes,
// default timing constants and a saturating counter helper.
package ps2_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_WAIT_START,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NACK     = 2'd1;
  localparam logic [1:0] ERR_START_TO = 2'd2;
  localparam logic [1:0] ERR_BIT_TO   = 2'd3;

  localparam int INHIBIT_CYC_DEF  = 5000;
  localparam int START_TO_CYC_DEF = 750000;
  localparam int BIT_TO_CYC_DEF   = 10000;

  localparam int CNT_W = 20;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus a
// one-cycle falling-edge pulse on the synchronized level.
module ps2_sync_edge (
  input  logic clock,
  input  logic resetn,
  input  logic pin,
  output logic sync,
  output logic fall
);

  logic meta;
  logic sync_q;

  // Idle bus level is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta   <= pin;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign fall = sync_q & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain via OE).
// Optional PS2_TX_RETRY_EN: retry failed attempts MAX_RETRY times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC  = INHIBIT_CYC_DEF,
  parameter int START_TO_CYC = START_TO_CYC_DEF,
  parameter int BIT_TO_CYC   = BIT_TO_CYC_DEF
`ifdef PS2_TX_RETRY_EN
  ,
  parameter int MAX_RETRY    = 2
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       send_valid,
  input  logic [7:0] send_data,
  output logic       send_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam logic [CNT_W-1:0] INH_LAST =
    CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] START_TO =
    CNT_W'(START_TO_CYC);
  localparam logic [CNT_W-1:0] BIT_TO =
    CNT_W'(BIT_TO_CYC);

  state_t           state;
  logic [9:0]       frame;
  logic [3:0]       bitn;
  logic [3:0]       bit_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sync_clk;
  logic             clk_fall;
  logic             data_meta;
  logic             sync_data;
  logic [1:0]       fail_code;
  logic             fail_final;

  ps2_sync_edge u_clk_sync (
    .clock  (clock),
    .resetn (resetn),
    .pin    (ps2_clk_in),
    .sync   (sync_clk),
    .fall   (clk_fall)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_meta <= 1'b1;
      sync_data <= 1'b1;
    end else begin
      data_meta <= ps2_data_in;
      sync_data <= data_meta;
    end
  end

`ifdef PS2_TX_RETRY_EN
  logic [3:0] retry_cnt;
  assign fail_final = retry_cnt >= 4'(MAX_RETRY);
`else
  assign fail_final = 1'b1;
`endif

  assign bit_nxt = bitn + 4'd1;

  always_comb begin
    fail_code = ERR_NONE;
    unique case (state)
      S_WAIT_START:
        if (!clk_fall && cnt >= START_TO)
          fail_code = ERR_START_TO;
      S_SHIFT:
        if (!clk_fall && cnt >= BIT_TO)
          fail_code = ERR_BIT_TO;
      S_ACK:
        if (clk_fall && sync_data)
          fail_code = ERR_NACK;
        else if (!clk_fall && cnt >= BIT_TO)
          fail_code = ERR_BIT_TO;
      S_WAIT_IDLE:
        if (!(sync_clk && sync_data) &&
            !clk_fall && cnt >= BIT_TO)
          fail_code = ERR_BIT_TO;
      default: fail_code = ERR_NONE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      frame       <= '0;
      bitn        <= '0;
      cnt         <= '0;
      send_ready  <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      err_code    <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      cnt     <= sat_inc(cnt);
      if (fail_code != ERR_NONE) begin
        state       <= S_FAIL;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_err      <= fail_final;
        if (fail_final)
          err_code <= fail_code;
      end else begin
        unique case (state)
          S_IDLE:
            if (send_valid) begin
              frame      <= {1'b1, ~^send_data, send_data};
              state      <= S_INHIBIT;
              send_ready <= 1'b0;
              tx_busy    <= 1'b1;
              ps2_clk_oe <= 1'b1;
              cnt        <= '0;
`ifdef PS2_TX_RETRY_EN
              retry_cnt  <= '0;
`endif
            end
          S_INHIBIT:
            if (cnt == INH_LAST) begin
              state       <= S_RTS;
              ps2_data_oe <= 1'b1;
            end
          S_RTS: begin
            state      <= S_WAIT_START;
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
          end
          S_WAIT_START:
            if (clk_fall) begin
              ps2_data_oe <= ~frame[0];
              bitn        <= '0;
              cnt         <= '0;
              state       <= S_SHIFT;
            end
          // frame[9] is the stop bit, so it releases the line
          S_SHIFT:
            if (clk_fall) begin
              cnt         <= '0;
              ps2_data_oe <= ~frame[bit_nxt];
              bitn        <= bit_nxt;
              if (bitn == 4'd8)
                state <= S_ACK;
            end
          S_ACK:
            if (clk_fall) begin
              cnt   <= '0;
              state <= S_WAIT_IDLE;
            end
          S_WAIT_IDLE:
            if (sync_clk && sync_data) begin
              state   <= S_DONE;
              tx_done <= 1'b1;
            end else if (clk_fall) begin
              cnt <= '0;
            end
          S_DONE: begin
            state      <= S_IDLE;
            tx_busy    <= 1'b0;
            send_ready <= 1'b1;
          end
          S_FAIL: begin
`ifdef PS2_TX_RETRY_EN
            if (!tx_err) begin
              retry_cnt  <= retry_cnt + 4'd1;
              state      <= S_INHIBIT;
              ps2_clk_oe <= 1'b1;
              cnt        <= '0;
            end else begin
              state      <= S_IDLE;
              tx_busy    <= 1'b0;
              send_ready <= 1'b1;
            end
`else
            state      <= S_IDLE;
            tx_busy    <= 1'b0;
            send_ready <= 1'b1;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2
// keyboard model driving the open-drain clock and data lines.
module tb_ps2_host_tx;

  logic       clock;
  logic       resetn;
  logic       send_valid;
  logic [7:0] send_data;
  logic       send_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;

  logic dev_clk;
  logic dev_data;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYC  (50),
    .START_TO_CYC (2000),
    .BIT_TO_CYC   (500)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .send_valid  (send_valid),
    .send_data   (send_data),
    .send_ready  (send_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .err_code    (err_code)
  );

`ifdef PS2_TX_RETRY_EN
  localparam int ATT = 3;
`else
  localparam int ATT = 1;
`endif

  typedef struct packed {
    logic       err;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_rel    = 0;
  int t_err    = 0;
  int last_fall = 0;
  int inh_run  = 0;
  int inh_len  = 0;
  int inh_cnt  = 0;
  logic clk_oe_q = 1'b0;
  logic inh_q    = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d",
               name, act, lo, hi);
    end
  endtask

  // Scoreboard monitor: pops one expectation per output pulse.
  always @(negedge clock) begin
    if (resetn && (tx_done || tx_err)) begin
      exp_t e;
      chk("done_err_excl", 32'(tx_done & tx_err), 0);
      if (tx_err) t_err = cyc;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", {30'd0, tx_err, tx_done}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_kind", 32'(tx_err), 32'(e.err));
        if (e.err)
          chk("sb_code", 32'(err_code), 32'(e.code));
      end
    end
  end

  // Line monitor: inhibit phase lengths and clock release time.
  always @(negedge clock) begin
    logic inh;
    inh = ps2_clk_oe & ~ps2_data_oe;
    if (inh) begin
      inh_run++;
    end else if (inh_q) begin
      inh_len = inh_run;
      inh_cnt++;
      inh_run = 0;
    end
    if (clk_oe_q && !ps2_clk_oe) t_rel = cyc;
    inh_q    = inh;
    clk_oe_q = ps2_clk_oe;
  end

  task automatic dev_xfer(input int npulse, input bit ack,
                          output logic [7:0] b,
                          output logic par,
                          output logic stp);
    int t;
    b = '0; par = 1'b0; stp = 1'b0; t = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && t < 5000) begin
      @(negedge clock);
      t++;
    end
    chk("dev_rts_seen", 32'(t < 5000), 1);
    repeat (30) @(negedge clock);
    for (int i = 0; i < npulse; i++) begin
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (20) @(negedge clock);
      dev_clk = 1'b1;
      if (i < 8) b[i] = ps2_data_in;
      else if (i == 8) par = ps2_data_in;
      else stp = ps2_data_in;
      repeat (20) @(negedge clock);
    end
    if (npulse == 10) begin
      if (ack) dev_data = 1'b0;
      repeat (5) @(negedge clock);
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (20) @(negedge clock);
      dev_clk = 1'b1;
      repeat (5) @(negedge clock);
      dev_data = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    send_valid = 1'b1;
    send_data  = b;
    @(negedge clock);
    send_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (tx_busy && t < 20000) begin
      @(negedge clock);
      t++;
    end
    chk("idle_reached", 32'(t < 20000), 1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic par;
    logic stp;
    int ic;
    resetn     = 1'b0;
    send_valid = 1'b0;
    send_data  = '0;
    dev_clk    = 1'b1;
    dev_data   = 1'b1;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_ready", 32'(send_ready), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    chk("rst_pulses", {30'd0, tx_done, tx_err}, 0);
    chk("rst_err_code", 32'(err_code), 0);

    // 0xED acknowledged: 6 ones, odd parity bit = 1
    exp_q.push_back('{err: 1'b0, code: 2'd0});
    send_byte(8'hED);
    dev_xfer(10, 1'b1, b, par, stp);
    wait_idle();
    chk("ed_inhibit_len", 32'(inh_len), 50);
    chk("ed_byte", 32'(b), 32'h00ED);
    chk("ed_parity", 32'(par), 1);
    chk("ed_stop", 32'(stp), 1);
    chk("ed_busy_low", 32'(tx_busy), 0);
    chk("ed_sb_empty", 32'(exp_q.size()), 0);

    // 0x00 acknowledged: parity 1, no error code
    exp_q.push_back('{err: 1'b0, code: 2'd0});
    send_byte(8'h00);
    dev_xfer(10, 1'b1, b, par, stp);
    wait_idle();
    chk("z_byte", 32'(b), 0);
    chk("z_parity", 32'(par), 1);
    chk("z_err_code", 32'(err_code), 0);
    chk("z_sb_empty", 32'(exp_q.size()), 0);

    // device never clocks
    exp_q.push_back('{err: 1'b1, code: 2'd2});
    send_byte(8'h12);
    wait_idle();
    chk_rng("start_to_delay", t_err - t_rel, 1999, 2004);
    chk("start_to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    chk("start_to_sb_empty", 32'(exp_q.size()), 0);

    // device stops after four bits
    exp_q.push_back('{err: 1'b1, code: 2'd3});
    send_byte(8'hF0);
    for (int a = 0; a < ATT; a++)
      dev_xfer(4, 1'b1, b, par, stp);
    wait_idle();
    chk_rng("bit_to_delay", t_err - last_fall, 499, 510);
    chk("bit_to_bits", 32'(b[3:0]), 0);
    chk("bit_to_sb_empty", 32'(exp_q.size()), 0);

    // device never pulls data low for ACK
    exp_q.push_back('{err: 1'b1, code: 2'd1});
    ic = inh_cnt;
    send_byte(8'hFF);
    for (int a = 0; a < ATT; a++)
      dev_xfer(10, 1'b0, b, par, stp);
    wait_idle();
    chk("nack_inhibits", 32'(inh_cnt - ic), 32'(ATT));
    chk("nack_byte", 32'(b), 32'h00FF);
    chk("nack_sb_empty", 32'(exp_q.size()), 0);

    // reset while shifting a zero bit
    send_byte(8'h00);
    dev_xfer(3, 1'b1, b, par, stp);
    chk("pre_rst_data_oe", 32'(ps2_data_oe), 1);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("rst_async_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_ready", 32'(send_ready), 1);
    chk("post_rst_busy", 32'(tx_busy), 0);
    chk("post_rst_err_code", 32'(err_code), 0);

    // send_valid while busy is ignored
    exp_q.push_back('{err: 1'b0, code: 2'd0});
    ic = inh_cnt;
    send_byte(8'hA5);
    fork
      dev_xfer(10, 1'b1, b, par, stp);
      begin
        repeat (200) @(negedge clock);
        send_valid = 1'b1;
        send_data  = 8'h3C;
        repeat (100) @(negedge clock);
        send_valid = 1'b0;
      end
    join
    wait_idle();
    repeat (100) @(negedge clock);
    chk("busy_byte", 32'(b), 32'h00A5);
    chk("busy_one_xfer", 32'(inh_cnt - ic), 1);
    chk("busy_idle_after", 32'(tx_busy), 0);
    chk("final_sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
